rv32_data_memory: RTL and testbench
===================================

RV32_DATA_MEMORY -- requirements
Module: rv32_data_memory

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 4096: RAM size in 32-bit words, power of two.
REQ-002 The block SHALL have parameter RAM_BASE, default 32'h1000_0000: RAM region base, aligned to DEPTH_WORDS*4.
REQ-003 The block SHALL have parameter MMIO_BASE, default 32'h2000_0000: 16-byte MMIO region base.
REQ-004 The block SHALL have port clk_i, input, 1: sole clock, rising edge.
REQ-005 The block SHALL have port rst_n_i, input, 1: reset, synchronous and active-low.
REQ-006 The block SHALL have port write_enable_i, input, 4: per-byte-lane store enables.
REQ-007 The block SHALL have port address_i, input, 32: byte address of the access.
REQ-008 The block SHALL have port write_data_i, input, 32: lane-aligned store data.
REQ-009 The block SHALL have port read_data_o, output, 32: full word for the address presented one cycle earlier.
REQ-010 The block SHALL have port access_fault_o, output, 1: registered, asserted with read_data_o when the prior address decoded to no region.
REQ-011 The block SHALL have port gpio_o, output, 32: GPIO register contents.

Function
REQ-012 Every cycle SHALL be an access: load-only when write_enable_i==0, otherwise store; there SHALL be no valid/ready handshake.
REQ-013 Read latency SHALL be exactly 1 cycle: read_data_o at edge N+1 reflects the address_i sampled at edge N.
REQ-014 Address bits [1:0] SHALL be ignored; the word index is address_i[log2(DEPTH_WORDS)+1:2].
REQ-015 RAM hit: (address_i - RAM_BASE) < DEPTH_WORDS*4; MMIO hit: address_i[31:4]==MMIO_BASE[31:4]; anything else SHALL be unmapped.
REQ-016 A RAM store SHALL update only the lanes whose write_enable_i bit is 1.
REQ-017 A RAM load with a simultaneous store to the same word SHALL return the old word (read-first).
REQ-018 MMIO offset 0x0 is GPIO: read/write, byte-enabled; the new value SHALL appear on gpio_o the cycle after the store.
REQ-019 MMIO offset 0x8 is CYC_LO: read-only lower 32 bits of the cycle counter.
REQ-020 A CYC_LO load SHALL capture the counter's upper 32 bits into a snapshot register at the same edge.
REQ-021 MMIO offset 0xC is CYC_HI: read-only, SHALL return the snapshot.
REQ-022 MMIO offset 0x4 SHALL read 0; stores to offsets 0x4, 0x8 and 0xC SHALL be ignored.
REQ-023 The cycle counter SHALL be 64 bits, increment every non-reset cycle, and wrap from 2^64-1 to 0.
REQ-024 An unmapped load SHALL return 32'h0 with access_fault_o=1 for one cycle; an unmapped store SHALL change nothing and SHALL assert access_fault_o the next cycle.
REQ-025 Back-to-back accesses to different regions SHALL each return correct data with no bubble.

Reset
REQ-026 While rst_n_i==0 at an edge, read_data_o, access_fault_o, gpio_o, the counter and the snapshot SHALL all go to 0.
REQ-027 RAM contents SHALL not be reset, and RAM writes SHALL be suppressed during reset.
REQ-028 If reset is asserted mid-sequence, the first access after release SHALL behave as if from idle, with no stale read data.

Structure
REQ-029 Package rv32_dmem_pkg SHALL hold the MMIO offsets (GPIO, RSVD, CYC_LO, CYC_HI) and a region enum {REG_RAM, REG_MMIO, REG_NONE}.
REQ-030 RAM storage SHALL be the sub-module rv32_dmem_bram: single-port, byte-enabled, read-first, with a registered output.
REQ-031 The region decode SHALL be registered alongside the address to select the read_data_o mux one cycle later.

Verification
REQ-032 Store 32'hDEADBEEF with we=4'hF to 0x1000_0010, then load it: read_data_o=32'hDEADBEEF one cycle after the load.
REQ-033 Then store 32'h0000_AA00 with we=4'b0010 to the same word, then load: read_data_o=32'hDEADAAEF.
REQ-034 Load and store 32'h1234_5678 to 0x1000_0020 in the same cycle (old value 0): returns 0; the next load returns 32'h1234_5678.
REQ-035 Load 0x3000_0000: read_data_o=0 and access_fault_o=1 for exactly one cycle; a following RAM load clears the fault.
REQ-036 Force the counter to 32'h0000_0000_FFFF_FFFF, load CYC_LO then CYC_HI: values 32'hFFFF_FFFF and 32'h0; the carry does not tear the pair.
REQ-037 Store 32'h0000_00A5 with we=4'h1 to GPIO, then assert reset for one cycle: gpio_o=0xA5, then 0; counter=0 and read_data_o=0 after release.

Source files
------------

// File: rtl/rv32_dmem_pkg.sv
// Shared definitions for the RV32 data memory: MMIO register map, region decode type and
// byte-lane merge helper.
package rv32_dmem_pkg;

  // MMIO word offsets within the 16-byte window
  localparam logic [3:0] MMIO_GPIO   = 4'h0;
  localparam logic [3:0] MMIO_RSVD   = 4'h4;
  localparam logic [3:0] MMIO_CYC_LO = 4'h8;
  localparam logic [3:0] MMIO_CYC_HI = 4'hC;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

  // Merge the enabled byte lanes of new_word over old_word
  function automatic logic [31:0] apply_be(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rv32_dmem_bram.sv
// Single-port byte-enabled RAM, read-first, registered read port. Contents are not reset.
module rv32_dmem_bram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              clk_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read the old word and write enabled lanes at the same edge (read-first)
  always_ff @(posedge clk_i) begin
    rdata_o <= mem[addr_i];
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/rv32_data_memory.sv
// RV32 data memory: RAM window, 16-byte MMIO window (GPIO + 64-bit cycle counter),
// everything else faults. One access per cycle, one cycle read latency.
module rv32_data_memory
  import rv32_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] RAM_BASE    = 32'h1000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'h2000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  write_enable_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        access_fault_o,
  output logic [31:0] gpio_o
);

  localparam int unsigned ADDR_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0] ram_off;
  region_e     region_d;
  region_e     region_q;
  logic [3:0]  mmio_off;
  logic        is_load;
  logic        mmio_acc;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] mmio_rdata_d;
  logic [31:0] mmio_rdata_q;
  logic [31:0] gpio_q;
  logic [31:0] snap_q;
  logic [63:0] cycle_q;
  logic        fault_q;

  assign mmio_off = {address_i[3:2], 2'b00};
  assign is_load  = (write_enable_i == 4'h0);
  assign mmio_acc = (region_d == REG_MMIO);

  // Region decode; subtraction wraps so addresses below RAM_BASE fall outside the window
  always_comb begin
    ram_off = address_i - RAM_BASE;
    if (ram_off < RAM_BYTES) begin
      region_d = REG_RAM;
    end else if (address_i[31:4] == MMIO_BASE[31:4]) begin
      region_d = REG_MMIO;
    end else begin
      region_d = REG_NONE;
    end
  end

  // RAM stores only on a RAM hit and never while reset is held
  assign ram_we = (rst_n_i && region_d == REG_RAM) ? write_enable_i : 4'h0;

  rv32_dmem_bram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_bram (
    .clk_i  (clk_i),
    .we_i   (ram_we),
    .addr_i (address_i[ADDR_W+1:2]),
    .wdata_i(write_data_i),
    .rdata_o(ram_rdata)
  );

  // MMIO read mux on pre-update register values (read-first like the RAM)
  always_comb begin
    mmio_rdata_d = 32'h0;
    case (mmio_off)
      MMIO_GPIO:   mmio_rdata_d = gpio_q;
      MMIO_CYC_LO: mmio_rdata_d = cycle_q[31:0];
      MMIO_CYC_HI: mmio_rdata_d = snap_q;
      default:     mmio_rdata_d = 32'h0;
    endcase
  end

  // Counter, GPIO, CYC_HI snapshot, and the registered region/fault/MMIO read data
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cycle_q      <= 64'h0;
      gpio_q       <= 32'h0;
      snap_q       <= 32'h0;
      mmio_rdata_q <= 32'h0;
      region_q     <= REG_NONE;
      fault_q      <= 1'b0;
    end else begin
      cycle_q      <= cycle_q + 64'd1;
      mmio_rdata_q <= mmio_rdata_d;
      region_q     <= region_d;
      fault_q      <= (region_d == REG_NONE);
      // Snapshot upper half with the lower-half load so the pair cannot tear on carry
      if (mmio_acc && is_load && mmio_off == MMIO_CYC_LO) snap_q <= cycle_q[63:32];
      if (mmio_acc && mmio_off == MMIO_GPIO) begin
        gpio_q <= apply_be(gpio_q, write_data_i, write_enable_i);
      end
    end
  end

  // Select the response for last cycle's access; REG_NONE (also the reset value) reads 0
  always_comb begin
    read_data_o = 32'h0;
    case (region_q)
      REG_RAM:  read_data_o = ram_rdata;
      REG_MMIO: read_data_o = mmio_rdata_q;
      default:  read_data_o = 32'h0;
    endcase
  end

  assign access_fault_o = fault_q;
  assign gpio_o         = gpio_q;

endmodule

// File: tb/tb_rv32_data_memory.sv
// Directed self-checking bench for rv32_data_memory.
module tb_rv32_data_memory;

  logic        clk;
  logic        rst_n;
  logic [3:0]  write_enable;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        access_fault;
  logic [31:0] gpio;

  int checks = 0;
  int errors = 0;

  rv32_data_memory dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .write_enable_i(write_enable),
    .address_i     (address),
    .write_data_i  (write_data),
    .read_data_o   (read_data),
    .access_fault_o(access_fault),
    .gpio_o        (gpio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one access at a negedge; on return the response of that access is visible
  task automatic acc(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    write_enable = we;
    address      = addr;
    write_data   = wd;
    @(negedge clk);
    write_enable = 4'h0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (read_data !== 32'h0) begin errors++;
      $display("FAIL reset_rdata: got %h expected %h", read_data, 32'h0); end
    checks++; if (access_fault !== 1'b0) begin errors++;
      $display("FAIL reset_fault: got %b expected 0", access_fault); end
    checks++; if (gpio !== 32'h0) begin errors++;
      $display("FAIL reset_gpio: got %h expected %h", gpio, 32'h0); end
    rst_n = 1'b1;
  endtask

  task automatic test_ram_byte_enable;
    acc(4'hF, 32'h1000_0010, 32'hDEAD_BEEF);
    acc(4'h0, 32'h1000_0010, 32'h0);
    checks++; if (read_data !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL ram_full_word: got %h expected %h", read_data, 32'hDEAD_BEEF); end
    checks++; if (access_fault !== 1'b0) begin errors++;
      $display("FAIL ram_no_fault: got %b expected 0", access_fault); end
    acc(4'b0010, 32'h1000_0010, 32'h0000_AA00);
    acc(4'h0, 32'h1000_0013, 32'h0);  // low address bits ignored
    checks++; if (read_data !== 32'hDEAD_AAEF) begin errors++;
      $display("FAIL ram_lane1: got %h expected %h", read_data, 32'hDEAD_AAEF); end
  endtask

  task automatic test_read_first;
    acc(4'hF, 32'h1000_0020, 32'h0);
    acc(4'hF, 32'h1000_0020, 32'h1234_5678);
    checks++; if (read_data !== 32'h0) begin errors++;
      $display("FAIL read_first_old: got %h expected %h", read_data, 32'h0); end
    acc(4'h0, 32'h1000_0020, 32'h0);
    checks++; if (read_data !== 32'h1234_5678) begin errors++;
      $display("FAIL read_first_new: got %h expected %h", read_data, 32'h1234_5678); end
  endtask

  task automatic test_fault;
    acc(4'h0, 32'h3000_0000, 32'h0);
    checks++; if (read_data !== 32'h0 || access_fault !== 1'b1) begin errors++;
      $display("FAIL unmapped_load: got %h/%b expected 0/1", read_data, access_fault); end
    acc(4'h0, 32'h1000_0010, 32'h0);
    checks++; if (read_data !== 32'hDEAD_AAEF || access_fault !== 1'b0) begin errors++;
      $display("FAIL fault_clear: got %h/%b expected deadaaef/0", read_data, access_fault); end
    acc(4'hF, 32'h1000_0000, 32'h1111_1111);
    acc(4'hF, 32'h1000_4000, 32'hFFFF_FFFF);  // one past the RAM end
    checks++; if (access_fault !== 1'b1) begin errors++;
      $display("FAIL unmapped_store: got %b expected 1", access_fault); end
    acc(4'hF, 32'h1000_3FFC, 32'hCAFE_F00D);  // last RAM word
    checks++; if (access_fault !== 1'b0) begin errors++;
      $display("FAIL ram_last_store: got %b expected 0", access_fault); end
    acc(4'h0, 32'h1000_3FFC, 32'h0);
    checks++; if (read_data !== 32'hCAFE_F00D) begin errors++;
      $display("FAIL ram_last_load: got %h expected %h", read_data, 32'hCAFE_F00D); end
    acc(4'h0, 32'h1000_0000, 32'h0);
    checks++; if (read_data !== 32'h1111_1111) begin errors++;
      $display("FAIL no_alias: got %h expected %h", read_data, 32'h1111_1111); end
    acc(4'h0, 32'h0FFF_FFFC, 32'h0);
    checks++; if (read_data !== 32'h0 || access_fault !== 1'b1) begin errors++;
      $display("FAIL below_base: got %h/%b expected 0/1", read_data, access_fault); end
  endtask

  task automatic test_mmio;
    acc(4'h1, 32'h2000_0000, 32'h0000_00A5);
    checks++; if (gpio !== 32'h0000_00A5) begin errors++;
      $display("FAIL gpio_store: got %h expected %h", gpio, 32'h0000_00A5); end
    acc(4'b0110, 32'h2000_0000, 32'h1234_5600);
    checks++; if (gpio !== 32'h0034_56A5) begin errors++;
      $display("FAIL gpio_be: got %h expected %h", gpio, 32'h0034_56A5); end
    acc(4'hF, 32'h2000_0004, 32'hFFFF_FFFF);
    acc(4'h0, 32'h2000_0004, 32'h0);
    checks++; if (read_data !== 32'h0 || access_fault !== 1'b0) begin errors++;
      $display("FAIL rsvd_read: got %h/%b expected 0/0", read_data, access_fault); end
    acc(4'hF, 32'h2000_000C, 32'hFFFF_FFFF);
    acc(4'h0, 32'h2000_0000, 32'h0);
    checks++; if (read_data !== 32'h0034_56A5 || gpio !== 32'h0034_56A5) begin errors++;
      $display("FAIL gpio_load: got %h/%h expected 003456a5", read_data, gpio); end
  endtask

  task automatic test_counter;
    write_enable = 4'h0;
    address      = 32'h2000_0008;
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    @(posedge clk);
    #1 release dut.cycle_q;
    @(negedge clk);
    checks++; if (read_data !== 32'hFFFF_FFFF) begin errors++;
      $display("FAIL cyc_lo: got %h expected %h", read_data, 32'hFFFF_FFFF); end
    acc(4'h0, 32'h2000_000C, 32'h0);
    checks++; if (read_data !== 32'h0) begin errors++;
      $display("FAIL cyc_hi_snapshot: got %h expected %h", read_data, 32'h0); end
    acc(4'h0, 32'h2000_0000, 32'h0);
    acc(4'h0, 32'h2000_0008, 32'h0);
    checks++; if (read_data > 32'd16) begin errors++;
      $display("FAIL cyc_lo_wrapped: got %h expected below 00000011", read_data); end
    acc(4'h0, 32'h2000_000C, 32'h0);
    checks++; if (read_data !== 32'h1) begin errors++;
      $display("FAIL cyc_hi_carry: got %h expected %h", read_data, 32'h1); end
  endtask

  task automatic test_back_to_back;
    acc(4'h0, 32'h1000_0010, 32'h0);
    checks++; if (read_data !== 32'hDEAD_AAEF) begin errors++;
      $display("FAIL b2b_ram: got %h expected %h", read_data, 32'hDEAD_AAEF); end
    acc(4'h0, 32'h2000_0000, 32'h0);
    checks++; if (read_data !== 32'h0034_56A5) begin errors++;
      $display("FAIL b2b_gpio: got %h expected %h", read_data, 32'h0034_56A5); end
    acc(4'h0, 32'h3000_0000, 32'h0);
    checks++; if (read_data !== 32'h0 || access_fault !== 1'b1) begin errors++;
      $display("FAIL b2b_unmapped: got %h/%b expected 0/1", read_data, access_fault); end
    acc(4'h0, 32'h1000_0020, 32'h0);
    checks++; if (read_data !== 32'h1234_5678 || access_fault !== 1'b0) begin errors++;
      $display("FAIL b2b_ram2: got %h/%b expected 12345678/0", read_data, access_fault); end
    acc(4'h0, 32'h2000_0004, 32'h0);
    checks++; if (read_data !== 32'h0) begin errors++;
      $display("FAIL b2b_rsvd: got %h expected %h", read_data, 32'h0); end
  endtask

  task automatic test_reset_midseq;
    acc(4'hF, 32'h2000_0000, 32'h0000_0000);
    acc(4'h1, 32'h2000_0000, 32'h0000_00A5);
    checks++; if (gpio !== 32'h0000_00A5) begin errors++;
      $display("FAIL mid_gpio_before: got %h expected %h", gpio, 32'h0000_00A5); end
    // A RAM load and store are in flight when reset hits
    rst_n = 1'b0;
    acc(4'hF, 32'h1000_0010, 32'h5555_5555);
    checks++; if (gpio !== 32'h0 || read_data !== 32'h0 || access_fault !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h/%h/%b expected 0/0/0",
               gpio, read_data, access_fault);
    end
    rst_n = 1'b1;
    acc(4'h0, 32'h2000_0008, 32'h0);
    checks++; if (read_data !== 32'h0 || access_fault !== 1'b0) begin errors++;
      $display("FAIL mid_counter_zero: got %h/%b expected 0/0", read_data, access_fault); end
    acc(4'h0, 32'h2000_0008, 32'h0);
    checks++; if (read_data !== 32'h1) begin errors++;
      $display("FAIL mid_counter_one: got %h expected %h", read_data, 32'h1); end
    acc(4'h0, 32'h1000_0010, 32'h0);
    checks++; if (read_data !== 32'hDEAD_AAEF) begin errors++;
      $display("FAIL mid_ram_kept: got %h expected %h", read_data, 32'hDEAD_AAEF); end
  endtask

  initial begin
    rst_n        = 1'b0;
    write_enable = 4'h0;
    address      = 32'h0;
    write_data   = 32'h0;
    test_reset();
    test_ram_byte_enable();
    test_read_first();
    test_fault();
    test_mmio();
    test_counter();
    test_back_to_back();
    test_reset_midseq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
